// File: rtl/vga_timing_gen.sv
//------------------------------------------------------------------------------
// vga_timing_gen
//
// Free-running raster timing generator for 640x480@60 Hz (default parameters).
// Runs from the 50 MHz board clock and derives a 25 MHz pixel strobe. It
// produces a registered position (hcount/vcount) with sync, blanking and
// line/frame start pulses that are all decoded from the same position, so the
// outputs never skew against each other.
//
// Ports:
//   clk          in   50 MHz system clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   pix_en       out  pixel strobe, high every other clk cycle
//   hcount[9:0]  out  horizontal position, 0..H_TOTAL-1
//   vcount[9:0]  out  vertical position, 0..V_TOTAL-1
//   hsync        out  horizontal sync, asserted level = SYNC_POL
//   vsync        out  vertical sync, asserted level = SYNC_POL
//   video_on     out  high while the position is inside the active area
//   line_start   out  one-clk pulse on the first cycle of each line
//   frame_start  out  one-clk pulse on the first cycle of each frame
//
// H_TOTAL and V_TOTAL must each be at most 1024 (10-bit counters).
//------------------------------------------------------------------------------
module vga_timing_gen #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter logic        SYNC_POL = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic       pix_en,
    output logic [9:0] hcount,
    output logic [9:0] vcount,
    output logic       hsync,
    output logic       vsync,
    output logic       video_on,
    output logic       line_start,
    output logic       frame_start
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_LAST       = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST       = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS_END    = 10'(H_ACTIVE);
    localparam logic [9:0] V_VIS_END    = 10'(V_ACTIVE);
    localparam logic [9:0] H_SYNC_START = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] H_SYNC_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] V_SYNC_START = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] V_SYNC_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

    // Look-ahead position: the position the outputs will show on the next
    // edge. It advances on the edge where pix_en is high, so the registered
    // outputs change one edge later, together with pix_en rising. That makes
    // every pixel last two cycles with pix_en high in the first of them.
    logic [9:0] h_pos;
    logic [9:0] v_pos;
    logic [9:0] h_pos_nxt;
    logic [9:0] v_pos_nxt;

    logic hsync_nxt;
    logic vsync_nxt;
    logic video_on_nxt;
    logic line_start_nxt;
    logic frame_start_nxt;

    // Position advance with horizontal and vertical wrap.
    always_comb begin
        // NOTE: every signal assigned in a combinational block gets a default
        // first; a path that leaves one unassigned would infer a latch.
        h_pos_nxt = h_pos;
        v_pos_nxt = v_pos;
        if (pix_en) begin
            if (h_pos == H_LAST) begin
                h_pos_nxt = '0;
                if (v_pos == V_LAST) begin
                    v_pos_nxt = '0;
                end else begin
                    v_pos_nxt = v_pos + 10'd1;
                end
            end else begin
                h_pos_nxt = h_pos + 10'd1;
            end
        end
    end

    // Decode of the position about to be presented on the outputs.
    always_comb begin
        hsync_nxt = ~SYNC_POL;
        vsync_nxt = ~SYNC_POL;
        if ((h_pos >= H_SYNC_START) && (h_pos < H_SYNC_END)) begin
            hsync_nxt = SYNC_POL;
        end
        if ((v_pos >= V_SYNC_START) && (v_pos < V_SYNC_END)) begin
            vsync_nxt = SYNC_POL;
        end
        video_on_nxt    = (h_pos < H_VIS_END) && (v_pos < V_VIS_END);
        // Next pix_en is ~pix_en: pulse only on the first cycle of pixel 0.
        line_start_nxt  = (h_pos == '0) && !pix_en;
        frame_start_nxt = line_start_nxt && (v_pos == '0);
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pix_en      <= 1'b0;
            h_pos       <= '0;
            v_pos       <= '0;
            hcount      <= '0;
            vcount      <= '0;
            hsync       <= ~SYNC_POL;
            vsync       <= ~SYNC_POL;
            video_on    <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            pix_en      <= ~pix_en;
            h_pos       <= h_pos_nxt;
            v_pos       <= v_pos_nxt;
            hcount      <= h_pos;
            vcount      <= v_pos;
            hsync       <= hsync_nxt;
            vsync       <= vsync_nxt;
            video_on    <= video_on_nxt;
            line_start  <= line_start_nxt;
            frame_start <= frame_start_nxt;
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
//------------------------------------------------------------------------------
// tb_vga_timing_gen
//
// Two instances share one clock:
//   dut_a : default 640x480 timing, active-low syncs (reset, horizontal timing)
//   dut_b : reduced 16x12 raster, active-high syncs, so whole frames, wraps and
//           a mid-frame reset fit in a short run.
//     dut_b geometry: H 8/2/3/3 (sync at h 10..12), V 6/2/2/2 (sync at v 8..9)
//     line = 32 cycles, frame = 384 cycles, vsync asserted 64 cycles.
// Outputs are sampled on the falling clock edge.
//------------------------------------------------------------------------------
module tb_vga_timing_gen;

    logic clk;
    logic rst_a_n;
    logic rst_b_n;

    logic       a_pix_en, a_hsync, a_vsync, a_video_on, a_line_start, a_frame_start;
    logic [9:0] a_hcount, a_vcount;
    logic       b_pix_en, b_hsync, b_vsync, b_video_on, b_line_start, b_frame_start;
    logic [9:0] b_hcount, b_vcount;

    int vectors    = 0;
    int miscompares = 0;

    vga_timing_gen dut_a (
        .clk         (clk),
        .rst_n       (rst_a_n),
        .pix_en      (a_pix_en),
        .hcount      (a_hcount),
        .vcount      (a_vcount),
        .hsync       (a_hsync),
        .vsync       (a_vsync),
        .video_on    (a_video_on),
        .line_start  (a_line_start),
        .frame_start (a_frame_start)
    );

    vga_timing_gen #(
        .H_ACTIVE (8), .H_FP (2), .H_SYNC (3), .H_BP (3),
        .V_ACTIVE (6), .V_FP (2), .V_SYNC (2), .V_BP (2),
        .SYNC_POL (1'b1)
    ) dut_b (
        .clk         (clk),
        .rst_n       (rst_b_n),
        .pix_en      (b_pix_en),
        .hcount      (b_hcount),
        .vcount      (b_vcount),
        .hsync       (b_hsync),
        .vsync       (b_vsync),
        .video_on    (b_video_on),
        .line_start  (b_line_start),
        .frame_start (b_frame_start)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    // Reset hold and the three-edge start-up sequence on dut_a.
    task automatic test_reset();
        rst_a_n = 1'b0;
        repeat (5) @(negedge clk);
        vectors++; if ({a_hsync, a_vsync} !== 2'b11) begin miscompares++; $display("FAIL a_rst_syncs: got %b expected 11", {a_hsync, a_vsync}); end
        vectors++; if ({a_pix_en, a_video_on, a_line_start, a_frame_start} !== 4'b0000) begin miscompares++; $display("FAIL a_rst_flags: got %b expected 0000", {a_pix_en, a_video_on, a_line_start, a_frame_start}); end
        vectors++; if ({a_hcount, a_vcount} !== 20'd0) begin miscompares++; $display("FAIL a_rst_pos: got %0d,%0d expected 0,0", a_hcount, a_vcount); end
        rst_a_n = 1'b1;
        @(negedge clk);
        vectors++; if ({a_pix_en, a_video_on, a_line_start, a_frame_start} !== 4'b1111) begin miscompares++; $display("FAIL a_edge1_flags: got %b expected 1111", {a_pix_en, a_video_on, a_line_start, a_frame_start}); end
        vectors++; if ({a_hcount, a_vcount} !== 20'd0) begin miscompares++; $display("FAIL a_edge1_pos: got %0d,%0d expected 0,0", a_hcount, a_vcount); end
        @(negedge clk);
        vectors++; if ({a_pix_en, a_line_start, a_frame_start} !== 3'b000) begin miscompares++; $display("FAIL a_edge2_flags: got %b expected 000", {a_pix_en, a_line_start, a_frame_start}); end
        vectors++; if ({a_hcount, a_vcount} !== 20'd0) begin miscompares++; $display("FAIL a_edge2_pos: got %0d,%0d expected 0,0", a_hcount, a_vcount); end
        @(negedge clk);
        vectors++; if (a_pix_en !== 1'b1 || a_hcount !== 10'd1 || a_line_start !== 1'b0) begin miscompares++; $display("FAIL a_edge3: got pix_en=%b h=%0d ls=%b expected 1,1,0", a_pix_en, a_hcount, a_line_start); end
    endtask

    // One full line on dut_a: period, hsync width and edges, video_on fall.
    task automatic test_horizontal();
        int n;
        int low_cnt;
        int fall_h;
        int vo_fall_h;
        int max_h;
        logic prev_hs;
        logic prev_vo;
        n = 0;
        do begin @(negedge clk); n++; end while (!a_line_start && n < 2000);
        vectors++;
        if (a_line_start !== 1'b1) begin miscompares++; $display("FAIL a_find_line_start: got timeout expected pulse"); return; end
        vectors++; if (a_vcount !== 10'd1 || a_hcount !== 10'd0 || a_pix_en !== 1'b1) begin miscompares++; $display("FAIL a_line1_start: got v=%0d h=%0d pix_en=%b expected 1,0,1", a_vcount, a_hcount, a_pix_en); end
        n = 0; low_cnt = 0; fall_h = -1; vo_fall_h = -1; max_h = 0;
        do begin
            if (a_hsync == 1'b0) low_cnt++;
            if (int'(a_hcount) > max_h) max_h = int'(a_hcount);
            prev_hs = a_hsync;
            prev_vo = a_video_on;
            @(negedge clk); n++;
            if (prev_hs && !a_hsync && fall_h < 0) fall_h = int'(a_hcount);
            if (prev_vo && !a_video_on && vo_fall_h < 0) vo_fall_h = int'(a_hcount);
        end while (!a_line_start && n < 2000);
        vectors++; if (n != 1600) begin miscompares++; $display("FAIL a_line_period: got %0d expected 1600", n); end
        vectors++; if (low_cnt != 192) begin miscompares++; $display("FAIL a_hsync_width: got %0d expected 192", low_cnt); end
        vectors++; if (fall_h != 656) begin miscompares++; $display("FAIL a_hsync_fall_h: got %0d expected 656", fall_h); end
        vectors++; if (vo_fall_h != 640) begin miscompares++; $display("FAIL a_video_on_fall_h: got %0d expected 640", vo_fall_h); end
        vectors++; if (max_h != 799) begin miscompares++; $display("FAIL a_hcount_max: got %0d expected 799", max_h); end
        vectors++; if (a_vcount !== 10'd2 || a_vsync !== 1'b1) begin miscompares++; $display("FAIL a_line2_start: got v=%0d vsync=%b expected 2,1", a_vcount, a_vsync); end
    endtask

    // Reset values and start-up of the active-high instance.
    task automatic test_polarity_reset();
        rst_b_n = 1'b0;
        repeat (5) @(negedge clk);
        vectors++; if ({b_hsync, b_vsync} !== 2'b00) begin miscompares++; $display("FAIL b_rst_syncs: got %b expected 00", {b_hsync, b_vsync}); end
        vectors++; if ({b_pix_en, b_video_on, b_line_start, b_frame_start, b_hcount, b_vcount} !== 24'd0) begin miscompares++; $display("FAIL b_rst_state: got h=%0d v=%0d flags=%b expected all 0", b_hcount, b_vcount, {b_pix_en, b_video_on, b_line_start, b_frame_start}); end
        rst_b_n = 1'b1;
        @(negedge clk);
        vectors++; if ({b_pix_en, b_video_on, b_frame_start, b_hsync, b_vsync} !== 5'b11100) begin miscompares++; $display("FAIL b_edge1: got %b expected 11100", {b_pix_en, b_video_on, b_frame_start, b_hsync, b_vsync}); end
        @(negedge clk);
        vectors++; if (b_pix_en !== 1'b0 || b_hcount !== 10'd0 || b_frame_start !== 1'b0) begin miscompares++; $display("FAIL b_edge2: got pix_en=%b h=%0d fs=%b expected 0,0,0", b_pix_en, b_hcount, b_frame_start); end
        @(negedge clk);
        vectors++; if (b_pix_en !== 1'b1 || b_hcount !== 10'd1) begin miscompares++; $display("FAIL b_edge3: got pix_en=%b h=%0d expected 1,1", b_pix_en, b_hcount); end
    endtask

    // One full frame on dut_b: period, sync windows, blanking, range limits.
    task automatic test_vertical();
        int n;
        int vs_cnt;
        int ls_cnt;
        int hs_bad;
        int vs_bad;
        int vo_bad;
        int max_h;
        int max_v;
        logic exp_vo;
        n = 0;
        do begin @(negedge clk); n++; end while (!b_frame_start && n < 1000);
        vectors++;
        if (b_frame_start !== 1'b1) begin miscompares++; $display("FAIL b_find_frame_start: got timeout expected pulse"); return; end
        n = 0; vs_cnt = 0; ls_cnt = 0; hs_bad = 0; vs_bad = 0; vo_bad = 0; max_h = 0; max_v = 0;
        do begin
            if (b_vsync) vs_cnt++;
            if (b_line_start) ls_cnt++;
            if (b_hsync !== (b_hcount >= 10'd10 && b_hcount <= 10'd12)) hs_bad++;
            if (b_vsync !== (b_vcount == 10'd8 || b_vcount == 10'd9)) vs_bad++;
            exp_vo = (b_hcount < 10'd8) && (b_vcount < 10'd6);
            if (b_video_on !== exp_vo) vo_bad++;
            if (int'(b_hcount) > max_h) max_h = int'(b_hcount);
            if (int'(b_vcount) > max_v) max_v = int'(b_vcount);
            @(negedge clk); n++;
        end while (!b_frame_start && n < 1000);
        vectors++; if (n != 384) begin miscompares++; $display("FAIL b_frame_period: got %0d expected 384", n); end
        vectors++; if (vs_cnt != 64) begin miscompares++; $display("FAIL b_vsync_width: got %0d expected 64", vs_cnt); end
        vectors++; if (ls_cnt != 12) begin miscompares++; $display("FAIL b_lines_per_frame: got %0d expected 12", ls_cnt); end
        vectors++; if (hs_bad != 0) begin miscompares++; $display("FAIL b_hsync_window: got %0d bad cycles expected 0", hs_bad); end
        vectors++; if (vs_bad != 0) begin miscompares++; $display("FAIL b_vsync_window: got %0d bad cycles expected 0", vs_bad); end
        vectors++; if (vo_bad != 0) begin miscompares++; $display("FAIL b_video_on_window: got %0d bad cycles expected 0", vo_bad); end
        vectors++; if (max_h != 15 || max_v != 11) begin miscompares++; $display("FAIL b_count_max: got %0d,%0d expected 15,11", max_h, max_v); end
    endtask

    // Frame wrap at (15,11) and line wrap at (15,3) on dut_b.
    task automatic test_wrap();
        int n;
        n = 0;
        while (!(b_hcount == 10'd15 && b_vcount == 10'd11 && b_pix_en) && n < 800) begin @(negedge clk); n++; end
        vectors++;
        if (n >= 800) begin miscompares++; $display("FAIL b_find_last_pixel: got timeout expected (15,11)"); return; end
        @(negedge clk);
        vectors++; if (b_hcount !== 10'd15 || b_vcount !== 10'd11 || b_pix_en !== 1'b0) begin miscompares++; $display("FAIL b_last_pixel_hold: got %0d,%0d pix_en=%b expected 15,11,0", b_hcount, b_vcount, b_pix_en); end
        @(negedge clk);
        vectors++; if (b_hcount !== 10'd0 || b_vcount !== 10'd0 || {b_pix_en, b_line_start, b_frame_start} !== 3'b111) begin miscompares++; $display("FAIL b_frame_wrap: got %0d,%0d flags=%b expected 0,0,111", b_hcount, b_vcount, {b_pix_en, b_line_start, b_frame_start}); end
        n = 0;
        while (!(b_hcount == 10'd15 && b_vcount == 10'd3 && b_pix_en) && n < 800) begin @(negedge clk); n++; end
        vectors++;
        if (n >= 800) begin miscompares++; $display("FAIL b_find_line_end: got timeout expected (15,3)"); return; end
        repeat (2) @(negedge clk);
        vectors++; if (b_hcount !== 10'd0 || b_vcount !== 10'd4 || {b_pix_en, b_line_start, b_frame_start} !== 3'b110) begin miscompares++; $display("FAIL b_line_wrap: got %0d,%0d flags=%b expected 0,4,110", b_hcount, b_vcount, {b_pix_en, b_line_start, b_frame_start}); end
    endtask

    // Asynchronous reset between edges during hsync, then restart on dut_b.
    task automatic test_mid_frame_reset();
        int n;
        n = 0;
        while (!(b_hcount == 10'd11 && b_vcount == 10'd4) && n < 800) begin @(negedge clk); n++; end
        vectors++;
        if (n >= 800) begin miscompares++; $display("FAIL b_find_mid_frame: got timeout expected (11,4)"); return; end
        vectors++; if (b_hsync !== 1'b1) begin miscompares++; $display("FAIL b_pre_reset_hsync: got %b expected 1", b_hsync); end
        #3 rst_b_n = 1'b0;
        #1;
        vectors++; if ({b_hcount, b_vcount} !== 20'd0) begin miscompares++; $display("FAIL b_async_clear_pos: got %0d,%0d expected 0,0", b_hcount, b_vcount); end
        vectors++; if ({b_pix_en, b_hsync, b_vsync, b_video_on, b_line_start, b_frame_start} !== 6'b000000) begin miscompares++; $display("FAIL b_async_clear_flags: got %b expected 000000", {b_pix_en, b_hsync, b_vsync, b_video_on, b_line_start, b_frame_start}); end
        repeat (2) @(negedge clk);
        rst_b_n = 1'b1;
        @(negedge clk);
        vectors++; if ({b_pix_en, b_video_on, b_line_start, b_frame_start} !== 4'b1111 || {b_hcount, b_vcount} !== 20'd0) begin miscompares++; $display("FAIL b_restart_edge1: got h=%0d v=%0d flags=%b expected 0,0,1111", b_hcount, b_vcount, {b_pix_en, b_video_on, b_line_start, b_frame_start}); end
        @(negedge clk);
        vectors++; if (b_pix_en !== 1'b0 || b_hcount !== 10'd0 || b_frame_start !== 1'b0) begin miscompares++; $display("FAIL b_restart_edge2: got pix_en=%b h=%0d fs=%b expected 0,0,0", b_pix_en, b_hcount, b_frame_start); end
        @(negedge clk);
        vectors++; if (b_pix_en !== 1'b1 || b_hcount !== 10'd1) begin miscompares++; $display("FAIL b_restart_edge3: got pix_en=%b h=%0d expected 1,1", b_pix_en, b_hcount); end
    endtask

    initial begin
        rst_a_n = 1'b0;
        rst_b_n = 1'b0;
        test_reset();
        test_horizontal();
        test_polarity_reset();
        test_vertical();
        test_wrap();
        test_mid_frame_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
